// File: rtl/boot_rom_patch_pkg.sv
// Shared definitions for the boot ROM patch controller: config register map,
// error response pattern and the patch entry record.
package boot_rom_patch_pkg;

    localparam int MAX_DATA_W = 64;
    localparam int MAX_ADDR_W = 32;

    localparam logic [3:0]  OFF_ADDR    = 4'h0;
    localparam logic [3:0]  OFF_DATA_LO = 4'h4;
    localparam logic [3:0]  OFF_DATA_HI = 4'h8;
    localparam logic [3:0]  OFF_CTRL    = 4'hC;
    localparam logic [11:0] OFF_LOCK    = 12'hFFC;

    localparam logic [31:0] ERR_PATTERN = 32'hBAD0_ACCE;

    typedef struct packed {
        logic                  en;
        logic [MAX_ADDR_W-1:0] addr;
        logic [MAX_DATA_W-1:0] data;
    } patch_entry_t;

endpackage

// File: rtl/boot_rom_patch_ctrl_if.sv
// Request/grant/rvalid read port of the boot ROM patch controller.
interface boot_rom_patch_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_i;
    logic [31:0]           add_i;
    logic                  gnt_o;
    logic                  rvalid_o;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  err_o;

    modport master (
        output req_i, add_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, add_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/boot_rom_patch_regfile.sv
// Patch entry storage, config port decode and lowest-index-wins patch lookup.
// Optional sticky write lock at 0xFFC when BOOT_ROM_PATCH_LOCK_EN is defined.
module boot_rom_patch_regfile
    import boot_rom_patch_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int WADDR_W    = 11,
    parameter int NUM_PATCH  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_req_i,
    input  logic                  cfg_we_i,
    input  logic [11:0]           cfg_addr_i,
    input  logic [31:0]           cfg_wdata_i,
    output logic                  cfg_ready_o,
    output logic [31:0]           cfg_rdata_o,
    input  logic [WADDR_W-1:0]    lookup_addr_i,
    output logic                  hit_o,
    output logic [DATA_WIDTH-1:0] hit_data_o
);

    localparam logic [7:0] NUM_PATCH_B = 8'(NUM_PATCH);

    patch_entry_t entries [NUM_PATCH];

    logic        cfg_acc;
    logic        cfg_wr;
    logic        lock_q;
    logic [7:0]  sel_idx;
    logic [3:0]  sel_off;
    logic        sel_hit;
    logic [31:0] rd_val;
    logic        unused_cfg_lsb;

    // A request is only taken while no completion is pending.
    assign cfg_acc        = cfg_req_i & ~cfg_ready_o;
    assign sel_idx        = cfg_addr_i[11:4];
    assign sel_off        = {cfg_addr_i[3:2], 2'b00};
    assign sel_hit        = sel_idx < NUM_PATCH_B;
    assign cfg_wr         = cfg_acc & cfg_we_i & sel_hit;
    assign unused_cfg_lsb = ^cfg_addr_i[1:0];

`ifdef BOOT_ROM_PATCH_LOCK_EN
    logic lock_sel;
    assign lock_sel = ({cfg_addr_i[11:2], 2'b00} == OFF_LOCK);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q <= 1'b0;
        end else if (cfg_acc && cfg_we_i && lock_sel && cfg_wdata_i[0]) begin
            lock_q <= 1'b1;
        end
    end
`else
    assign lock_q = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_PATCH; i++) begin
                entries[i] <= '0;
            end
        end else if (cfg_wr && !lock_q) begin
            for (int i = 0; i < NUM_PATCH; i++) begin
                if (sel_idx == 8'(i)) begin
                    case (sel_off)
                        OFF_ADDR:    entries[i].addr <= MAX_ADDR_W'(cfg_wdata_i[WADDR_W-1:0]);
                        OFF_DATA_LO: entries[i].data[31:0] <= cfg_wdata_i;
                        OFF_DATA_HI: begin
                            if (DATA_WIDTH == 64) begin
                                entries[i].data[63:32] <= cfg_wdata_i;
                            end
                        end
                        OFF_CTRL:    entries[i].en <= cfg_wdata_i[0];
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_PATCH; i++) begin
            if (sel_hit && sel_idx == 8'(i)) begin
                case (sel_off)
                    OFF_ADDR:    rd_val = entries[i].addr;
                    OFF_DATA_LO: rd_val = entries[i].data[31:0];
                    OFF_DATA_HI: rd_val = entries[i].data[63:32];
                    default:     rd_val = {31'b0, entries[i].en};
                endcase
            end
        end
`ifdef BOOT_ROM_PATCH_LOCK_EN
        if (lock_sel) begin
            rd_val = {31'b0, lock_q};
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg_ready_o <= 1'b0;
            cfg_rdata_o <= '0;
        end else begin
            cfg_ready_o <= cfg_acc;
            cfg_rdata_o <= (cfg_acc && !cfg_we_i) ? rd_val : '0;
        end
    end

    // Scan from the top so the lowest matching index is the last assignment.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        for (int i = NUM_PATCH - 1; i >= 0; i--) begin
            if (entries[i].en && entries[i].addr == MAX_ADDR_W'(lookup_addr_i)) begin
                hit_o      = 1'b1;
                hit_data_o = entries[i].data[DATA_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/boot_rom_patch_ctrl.sv
// Boot ROM controller with run-time word patching and out-of-range error response.
// Patch lock register is built in when BOOT_ROM_PATCH_LOCK_EN is defined.
module boot_rom_patch_ctrl
    import boot_rom_patch_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ROM_ADDR_WIDTH = 13,
    parameter int NUM_PATCH      = 4,
    parameter int OUT_REG        = 0,
    localparam int OFFS          = $clog2(DATA_WIDTH / 8)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    boot_rom_patch_ctrl_if.slave             bus,
    output logic                             rom_cen_o,
    output logic [ROM_ADDR_WIDTH-OFFS-1:0]   rom_addr_o,
    input  logic [DATA_WIDTH-1:0]            rom_rdata_i,
    input  logic                             cfg_req_i,
    input  logic                             cfg_we_i,
    input  logic [11:0]                      cfg_addr_i,
    input  logic [31:0]                      cfg_wdata_i,
    output logic                             cfg_ready_o,
    output logic [31:0]                      cfg_rdata_o
);

    localparam int WADDR_W = ROM_ADDR_WIDTH - OFFS;
    localparam logic [DATA_WIDTH-1:0] ERR_DATA = {(DATA_WIDTH / 32){ERR_PATTERN}};

    logic                  accept;
    logic                  in_range;
    logic [WADDR_W-1:0]    word_addr;
    logic                  hit;
    logic [DATA_WIDTH-1:0] hit_data;
    logic                  vld_p0;
    logic                  err_p0;
    logic                  hit_p0;
    logic [DATA_WIDTH-1:0] pdata_p0;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  unused_addr_lsb;

    assign bus.gnt_o       = bus.req_i & ~rst_i;
    assign accept          = bus.req_i & bus.gnt_o;
    assign in_range        = ({1'b0, bus.add_i} < (33'd1 << ROM_ADDR_WIDTH));
    assign word_addr       = bus.add_i[ROM_ADDR_WIDTH-1:OFFS];
    assign unused_addr_lsb = ^bus.add_i[OFFS-1:0];

    assign rom_cen_o  = ~(accept & in_range);
    assign rom_addr_o = word_addr;

    boot_rom_patch_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .WADDR_W    (WADDR_W),
        .NUM_PATCH  (NUM_PATCH)
    ) u_regfile (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .cfg_req_i     (cfg_req_i),
        .cfg_we_i      (cfg_we_i),
        .cfg_addr_i    (cfg_addr_i),
        .cfg_wdata_i   (cfg_wdata_i),
        .cfg_ready_o   (cfg_ready_o),
        .cfg_rdata_o   (cfg_rdata_o),
        .lookup_addr_i (word_addr),
        .hit_o         (hit),
        .hit_data_o    (hit_data)
    );

    // Stage p0: accept cycle, ROM access launched, patch lookup captured
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p0   <= 1'b0;
            err_p0   <= 1'b0;
            hit_p0   <= 1'b0;
            pdata_p0 <= '0;
        end else begin
            vld_p0 <= accept;
            if (accept) begin
                err_p0   <= ~in_range;
                hit_p0   <= hit;
                pdata_p0 <= hit_data;
            end
        end
    end

    assign resp_data = err_p0 ? ERR_DATA : (hit_p0 ? pdata_p0 : rom_rdata_i);

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  vld_p1;
            logic                  err_p1;
            logic [DATA_WIDTH-1:0] rdata_p1;

            // Stage p1: optional response register
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    vld_p1   <= 1'b0;
                    err_p1   <= 1'b0;
                    rdata_p1 <= '0;
                end else begin
                    vld_p1 <= vld_p0;
                    if (vld_p0) begin
                        err_p1   <= err_p0;
                        rdata_p1 <= resp_data;
                    end
                end
            end

            assign bus.rvalid_o = vld_p1;
            assign bus.err_o    = vld_p1 & err_p1;
            assign bus.rdata_o  = vld_p1 ? rdata_p1 : '0;
        end else begin : g_no_out_reg
            assign bus.rvalid_o = vld_p0;
            assign bus.err_o    = vld_p0 & err_p0;
            assign bus.rdata_o  = vld_p0 ? resp_data : '0;
        end
    endgenerate

endmodule

// File: tb/tb_boot_rom_patch_ctrl.sv
// Directed bench: a 32-bit single-latency instance and a 64-bit registered-output
// instance driven by the same request and config stimulus.
module tb_boot_rom_patch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] add;
    logic        cfg_req;
    logic        cfg_we;
    logic [11:0] cfg_addr;
    logic [31:0] cfg_wdata;

    logic        rom_cen_a, rom_cen_b;
    logic [10:0] rom_addr_a;
    logic [9:0]  rom_addr_b;
    logic [31:0] rom_q_a;
    logic [63:0] rom_q_b;
    logic        cfg_ready_a, cfg_ready_b;
    logic [31:0] cfg_rdata_a, cfg_rdata_b;

    int n_cmp = 0;
    int n_bad = 0;

    boot_rom_patch_ctrl_if #(.DATA_WIDTH(32)) bus_a ();
    boot_rom_patch_ctrl_if #(.DATA_WIDTH(64)) bus_b ();

    assign bus_a.req_i = req;
    assign bus_a.add_i = add;
    assign bus_b.req_i = req;
    assign bus_b.add_i = add;

    always #5 clk = ~clk;

    boot_rom_patch_ctrl #(
        .DATA_WIDTH(32), .ROM_ADDR_WIDTH(13), .NUM_PATCH(4), .OUT_REG(0)
    ) u_dut_a (
        .clk_i(clk), .rst_i(rst), .bus(bus_a),
        .rom_cen_o(rom_cen_a), .rom_addr_o(rom_addr_a), .rom_rdata_i(rom_q_a),
        .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
        .cfg_ready_o(cfg_ready_a), .cfg_rdata_o(cfg_rdata_a)
    );

    boot_rom_patch_ctrl #(
        .DATA_WIDTH(64), .ROM_ADDR_WIDTH(13), .NUM_PATCH(4), .OUT_REG(1)
    ) u_dut_b (
        .clk_i(clk), .rst_i(rst), .bus(bus_b),
        .rom_cen_o(rom_cen_b), .rom_addr_o(rom_addr_b), .rom_rdata_i(rom_q_b),
        .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
        .cfg_ready_o(cfg_ready_b), .cfg_rdata_o(cfg_rdata_b)
    );

    // Synchronous ROM contents: word n holds C0DE_000n (low) / 5EED_000n (high).
    always @(posedge clk) begin
        if (!rom_cen_a) rom_q_a <= 32'hC0DE_0000 + 32'(rom_addr_a);
        if (!rom_cen_b) rom_q_b <= {32'h5EED_0000 + 32'(rom_addr_b), 32'hC0DE_0000 + 32'(rom_addr_b)};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_access(input logic we, input logic [11:0] a, input logic [31:0] wd,
                              output logic [31:0] rd_a, output logic [31:0] rd_b);
        cfg_req = 1'b1; cfg_we = we; cfg_addr = a; cfg_wdata = wd;
        tick();
        rd_a = cfg_rdata_a;
        rd_b = cfg_rdata_b;
        chk("cfg_ready", 64'({cfg_ready_a, cfg_ready_b}), 64'(2'b11));
        cfg_req = 1'b0; cfg_we = 1'b0;
        tick();
    endtask

    task automatic cfg_wr(input logic [11:0] a, input logic [31:0] wd);
        logic [31:0] da, db;
        cfg_access(1'b1, a, wd, da, db);
    endtask

    task automatic cfg_rd_chk(input string tag, input logic [11:0] a,
                              input logic [31:0] exp_a, input logic [31:0] exp_b);
        logic [31:0] da, db;
        cfg_access(1'b0, a, 32'h0, da, db);
        chk({tag, ".a"}, 64'(da), 64'(exp_a));
        chk({tag, ".b"}, 64'(db), 64'(exp_b));
    endtask

    // One accepted read, optionally with a config write in the same cycle.
    task automatic do_read(input string tag, input logic [31:0] a,
                           input logic [31:0] exp_a, input logic [63:0] exp_b, input logic exp_err,
                           input logic with_cfg, input logic [11:0] ca, input logic [31:0] cd);
        logic exp_cen;
        exp_cen = (a >= 32'h2000);
        req = 1'b1; add = a;
        if (with_cfg) begin
            cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = ca; cfg_wdata = cd;
        end
        #1;
        chk({tag, ".gnt"}, 64'({bus_a.gnt_o, bus_b.gnt_o}), 64'(2'b11));
        chk({tag, ".cen"}, 64'({rom_cen_a, rom_cen_b}), 64'({exp_cen, exp_cen}));
        tick();
        req = 1'b0; cfg_req = 1'b0; cfg_we = 1'b0;
        chk({tag, ".a.vld"}, 64'({bus_a.rvalid_o, bus_a.err_o, bus_b.rvalid_o}), 64'({1'b1, exp_err, 1'b0}));
        chk({tag, ".a.data"}, 64'(bus_a.rdata_o), 64'(exp_a));
        tick();
        chk({tag, ".b.vld"}, 64'({bus_b.rvalid_o, bus_b.err_o, bus_a.rvalid_o}), 64'({1'b1, exp_err, 1'b0}));
        chk({tag, ".b.data"}, bus_b.rdata_o, exp_b);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; add = '0;
        cfg_req = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        repeat (3) tick();

        // Reset state, with a request pending that must not be granted
        req = 1'b1; add = 32'h4; #1;
        chk("rst.gnt", 64'({bus_a.gnt_o, bus_b.gnt_o}), 64'(0));
        chk("rst.cen", 64'({rom_cen_a, rom_cen_b}), 64'(2'b11));
        chk("rst.rvalid_err", 64'({bus_a.rvalid_o, bus_b.rvalid_o, bus_a.err_o, bus_b.err_o}), 64'(0));
        chk("rst.rdata_a", 64'(bus_a.rdata_o), 64'(0));
        chk("rst.rdata_b", bus_b.rdata_o, 64'(0));
        chk("rst.cfg_ready", 64'({cfg_ready_a, cfg_ready_b}), 64'(0));
        chk("rst.cfg_rdata", 64'({cfg_rdata_a, cfg_rdata_b}), 64'(0));
        req = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Back-to-back reads at 0x0, 0x4, 0x8
        req = 1'b1; add = 32'h0; #1;
        chk("b2b.gnt", 64'({bus_a.gnt_o, bus_b.gnt_o}), 64'(2'b11));
        chk("b2b.rom_addr0", 64'({rom_addr_a, rom_addr_b}), 64'(0));
        tick();
        chk("b2b.a0.vld", 64'({bus_a.rvalid_o, bus_a.err_o, bus_b.rvalid_o}), 64'(3'b100));
        chk("b2b.a0.data", 64'(bus_a.rdata_o), 64'(32'hC0DE_0000));
        add = 32'h4; #1;
        chk("b2b.rom_addr1", 64'({rom_addr_a, rom_addr_b}), 64'({11'd1, 10'd0}));
        tick();
        chk("b2b.a1.vld", 64'({bus_a.rvalid_o, bus_a.err_o}), 64'(2'b10));
        chk("b2b.a1.data", 64'(bus_a.rdata_o), 64'(32'hC0DE_0001));
        chk("b2b.b0.vld", 64'({bus_b.rvalid_o, bus_b.err_o}), 64'(2'b10));
        chk("b2b.b0.data", bus_b.rdata_o, {32'h5EED_0000, 32'hC0DE_0000});
        add = 32'h8;
        tick();
        req = 1'b0;
        chk("b2b.a2.vld", 64'({bus_a.rvalid_o, bus_a.err_o}), 64'(2'b10));
        chk("b2b.a2.data", 64'(bus_a.rdata_o), 64'(32'hC0DE_0002));
        chk("b2b.b1.vld", 64'({bus_b.rvalid_o, bus_b.err_o}), 64'(2'b10));
        chk("b2b.b1.data", bus_b.rdata_o, {32'h5EED_0000, 32'hC0DE_0000});
        tick();
        chk("b2b.a.idle", 64'(bus_a.rvalid_o), 64'(0));
        chk("b2b.b2.vld", 64'({bus_b.rvalid_o, bus_b.err_o}), 64'(2'b10));
        chk("b2b.b2.data", bus_b.rdata_o, {32'h5EED_0001, 32'hC0DE_0001});
        tick();
        chk("b2b.b.idle", 64'(bus_b.rvalid_o), 64'(0));

        // Single patch on entry 0, register readback
        cfg_wr(12'h000, 32'h1);
        cfg_wr(12'h004, 32'h1234_5678);
        cfg_wr(12'h008, 32'hCAFE_F00D);
        cfg_wr(12'h00C, 32'h1);
        cfg_wr(12'h030, 32'hFFFF_FFFF);
        cfg_rd_chk("rd.e0addr", 12'h000, 32'h1, 32'h1);
        cfg_rd_chk("rd.e0lo", 12'h004, 32'h1234_5678, 32'h1234_5678);
        cfg_rd_chk("rd.e0hi", 12'h008, 32'h0, 32'hCAFE_F00D);
        cfg_rd_chk("rd.e0ctrl", 12'h00C, 32'h1, 32'h1);
        cfg_rd_chk("rd.e3addr", 12'h030, 32'h7FF, 32'h3FF);
        cfg_rd_chk("rd.unmap40", 12'h040, 32'h0, 32'h0);
        cfg_rd_chk("rd.unmap800", 12'h800, 32'h0, 32'h0);
        do_read("p.0x4", 32'h4, 32'h1234_5678, {32'h5EED_0000, 32'hC0DE_0000}, 1'b0, 1'b0, 12'h0, 32'h0);
        do_read("p.0x8", 32'h8, 32'hC0DE_0002, {32'hCAFE_F00D, 32'h1234_5678}, 1'b0, 1'b0, 12'h0, 32'h0);

        // Entries 0 and 2 on the same word: lowest index wins
        cfg_wr(12'h000, 32'h5);
        cfg_wr(12'h004, 32'h1111_0000);
        cfg_wr(12'h020, 32'h5);
        cfg_wr(12'h024, 32'h2222_0000);
        cfg_wr(12'h028, 32'h3333_0000);
        cfg_wr(12'h02C, 32'h1);
        do_read("pri.0x14", 32'h14, 32'h1111_0000, {32'h5EED_0002, 32'hC0DE_0002}, 1'b0, 1'b0, 12'h0, 32'h0);
        do_read("pri.0x28", 32'h28, 32'hC0DE_000A, {32'hCAFE_F00D, 32'h1111_0000}, 1'b0, 1'b0, 12'h0, 32'h0);
        cfg_wr(12'h00C, 32'h0);
        do_read("pri2.0x14", 32'h14, 32'h2222_0000, {32'h5EED_0002, 32'hC0DE_0002}, 1'b0, 1'b0, 12'h0, 32'h0);
        do_read("pri2.0x28", 32'h28, 32'hC0DE_000A, {32'h3333_0000, 32'h2222_0000}, 1'b0, 1'b0, 12'h0, 32'h0);

        // Window boundary, out-of-range error, ignored byte-offset bits
        do_read("oor.2000", 32'h2000, 32'hBAD0_ACCE, {2{32'hBAD0_ACCE}}, 1'b1, 1'b0, 12'h0, 32'h0);
        do_read("oor.fffc", 32'hFFFF_FFFC, 32'hBAD0_ACCE, {2{32'hBAD0_ACCE}}, 1'b1, 1'b0, 12'h0, 32'h0);
        do_read("top.1ffc", 32'h1FFC, 32'hC0DE_07FF, {32'h5EED_03FF, 32'hC0DE_03FF}, 1'b0, 1'b0, 12'h0, 32'h0);
        do_read("lsb.0x7", 32'h7, 32'hC0DE_0001, {32'h5EED_0000, 32'hC0DE_0000}, 1'b0, 1'b0, 12'h0, 32'h0);

        // Config write in the accept cycle only affects the following accept
        cfg_wr(12'h00C, 32'h1);
        do_read("same.a", 32'h14, 32'h1111_0000, {32'h5EED_0002, 32'hC0DE_0002}, 1'b0, 1'b1, 12'h004, 32'h4444_0000);
        do_read("same.b", 32'h28, 32'hC0DE_000A, {32'hCAFE_F00D, 32'h4444_0000}, 1'b0, 1'b1, 12'h004, 32'h5555_0000);
        do_read("after.b", 32'h28, 32'hC0DE_000A, {32'hCAFE_F00D, 32'h5555_0000}, 1'b0, 1'b0, 12'h0, 32'h0);
        do_read("after.a", 32'h14, 32'h5555_0000, {32'h5EED_0002, 32'hC0DE_0002}, 1'b0, 1'b0, 12'h0, 32'h0);

`ifdef BOOT_ROM_PATCH_LOCK_EN
        cfg_wr(12'hFFC, 32'h1);
        cfg_rd_chk("lock.rd", 12'hFFC, 32'h1, 32'h1);
        cfg_wr(12'h014, 32'h9999_9999);
        cfg_wr(12'h01C, 32'h1);
        cfg_wr(12'h00C, 32'h0);
        cfg_wr(12'hFFC, 32'h0);
        cfg_rd_chk("lock.e1lo", 12'h014, 32'h0, 32'h0);
        cfg_rd_chk("lock.e1ctrl", 12'h01C, 32'h0, 32'h0);
        cfg_rd_chk("lock.sticky", 12'hFFC, 32'h1, 32'h1);
        do_read("lock.0x14", 32'h14, 32'h5555_0000, {32'h5EED_0002, 32'hC0DE_0002}, 1'b0, 1'b0, 12'h0, 32'h0);
`else
        cfg_wr(12'hFFC, 32'h1);
        cfg_rd_chk("nolock.rd", 12'hFFC, 32'h0, 32'h0);
        cfg_wr(12'h014, 32'h9999_9999);
        cfg_rd_chk("nolock.e1lo", 12'h014, 32'h9999_9999, 32'h9999_9999);
`endif

        // Reset one cycle after an accept drops the response and clears patches
        req = 1'b1; add = 32'h14;
        tick();
        req = 1'b0;
        rst = 1'b1; #1;
        chk("mid.rvalid", 64'({bus_a.rvalid_o, bus_b.rvalid_o}), 64'(0));
        repeat (2) begin
            tick();
            chk("mid.hold", 64'({bus_a.rvalid_o, bus_b.rvalid_o}), 64'(0));
        end
        rst = 1'b0;
        repeat (3) begin
            tick();
            chk("post.rvalid", 64'({bus_a.rvalid_o, bus_b.rvalid_o}), 64'(0));
        end
        cfg_rd_chk("post.e0lo", 12'h004, 32'h0, 32'h0);
        cfg_rd_chk("post.e0ctrl", 12'h00C, 32'h0, 32'h0);
        cfg_rd_chk("post.e2addr", 12'h020, 32'h0, 32'h0);
        cfg_rd_chk("post.lock", 12'hFFC, 32'h0, 32'h0);
        do_read("post.0x14", 32'h14, 32'hC0DE_0005, {32'h5EED_0002, 32'hC0DE_0002}, 1'b0, 1'b0, 12'h0, 32'h0);

        // Held cfg_req completes every second cycle
        cfg_wr(12'h004, 32'hA5A5_A5A5);
        cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = 12'h004;
        tick();
        chk("hold.r1", 64'({cfg_ready_a, cfg_ready_b}), 64'(2'b11));
        chk("hold.d1", 64'(cfg_rdata_a), 64'(32'hA5A5_A5A5));
        tick();
        chk("hold.r2", 64'({cfg_ready_a, cfg_ready_b}), 64'(0));
        tick();
        chk("hold.r3", 64'({cfg_ready_a, cfg_ready_b}), 64'(2'b11));
        chk("hold.d3", 64'(cfg_rdata_b), 64'(32'hA5A5_A5A5));
        cfg_req = 1'b0;
        tick();
        chk("hold.r4", 64'({cfg_ready_a, cfg_ready_b}), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
